// File: rtl/barcode_line_scanner.sv
// Per-scanline EAN-13 / EAN-8 module extractor: measures module pitch from the start guard,
// samples every module at its centre in fixed point and checks guards and digit framing.
module barcode_line_scanner #(
  parameter int unsigned MIN_MODULE_WIDTH = 2,
  parameter int unsigned MAX_MODULE_WIDTH = 16,
  parameter int unsigned TOL_MODULE_WIDTH = 2,
  parameter int unsigned FRAC_BITS        = 4,
  parameter bit          INVERT           = 1'b1
) (
  input  logic        iClk,
  input  logic        iRst,
  input  logic        iPixelEn,
  input  logic        iPixelActive,
  input  logic        iPixelData,
  input  logic        iLineStart,
  input  logic        iMode,
  output logic        oVideoModule,
  output logic        oVideoMarker,
  output logic        oVideoDigit,
  output logic [83:0] oDataCode,
  output logic        oNewData,
  output logic        oErr,
  output logic [2:0]  oErrCode
);

  localparam int unsigned PosW = $clog2(95 * MAX_MODULE_WIDTH + 1) + FRAC_BITS;
  localparam int unsigned CntW = $clog2(MAX_MODULE_WIDTH + TOL_MODULE_WIDTH + 2);

  localparam logic [PosW-1:0] PosStep = PosW'(1) << FRAC_BITS;
  localparam logic [PosW-1:0] TolFx   = PosW'(TOL_MODULE_WIDTH) << FRAC_BITS;
  localparam logic [CntW-1:0] CntMin  = CntW'(MIN_MODULE_WIDTH);
  localparam logic [CntW-1:0] CntMax  = CntW'(MAX_MODULE_WIDTH);
  localparam logic [CntW-1:0] CntMax2 = CntW'(MAX_MODULE_WIDTH + TOL_MODULE_WIDTH);
  localparam logic [83:0]     Ean8Mask = {28'd0, {56{1'b1}}};

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StLeft,
    StMid,
    StRight,
    StEnd
  } stateT;

  stateT            stateQ, stateD;
  logic [1:0]       phaseQ, phaseD;
  logic [CntW-1:0]  cntQ, cntD;
  logic [CntW-1:0]  w0Q, w0D;
  logic [PosW-1:0]  widthQ, widthD;
  logic [PosW-1:0]  posQ, posD;
  logic [PosW-1:0]  spQ, spD;
  logic [2:0]       bitQ, bitD;
  logic [2:0]       digitQ, digitD;
  logic [83:0]      codeQ, codeD;
  logic [83:0]      dataCodeQ, dataCodeD;
  logic             newDataQ, newDataD;
  logic             errQ, errD;
  logic [2:0]       errCodeQ, errCodeD;
  logic             bPrevQ, bPrevD;
  logic             modeQ, modeD;
  logic             vidModuleQ, vidModuleD;
  logic             vidMarkerQ, vidMarkerD;
  logic             vidDigitQ, vidDigitD;

  logic             bar;
  logic             rise;
  logic             lineBreak;
  logic [PosW-1:0]  posNext;
  logic             takeSample;
  logic [PosW-1:0]  widthFromStart;
  logic [PosW-1:0]  bar2Fx;
  logic [PosW-1:0]  bar2Diff;
  logic             bar2Ok;
  logic [2:0]       lastDigit;
  logic             halfFirst;
  logic             abortEn;
  logic [2:0]       abortCode;

  assign bar       = iPixelData ^ INVERT;
  assign rise      = bar & ~bPrevQ;
  assign lineBreak = ~iPixelActive | iLineStart;
  assign posNext   = posQ + PosStep;
  assign takeSample = (posNext >= spQ);
  assign lastDigit = modeQ ? 3'd3 : 3'd5;
  // Left-half digits open with a space, right-half digits with a bar.
  assign halfFirst = (stateQ == StRight);

  // Module width in fixed point is the mean of the first bar and space.
  assign widthFromStart = ((PosW'(w0Q) + PosW'(cntQ)) << FRAC_BITS) >> 1;
  assign bar2Fx   = PosW'(cntQ) << FRAC_BITS;
  assign bar2Diff = (bar2Fx > widthQ) ? (bar2Fx - widthQ) : (widthQ - bar2Fx);
  assign bar2Ok   = (bar2Diff <= TolFx);

  always_comb begin
    stateD     = stateQ;
    phaseD     = phaseQ;
    cntD       = cntQ;
    w0D        = w0Q;
    widthD     = widthQ;
    posD       = posQ;
    spD        = spQ;
    bitD       = bitQ;
    digitD     = digitQ;
    codeD      = codeQ;
    dataCodeD  = dataCodeQ;
    newDataD   = 1'b0;
    errD       = 1'b0;
    errCodeD   = errCodeQ;
    bPrevD     = bPrevQ;
    modeD      = modeQ;
    vidModuleD = vidModuleQ;
    vidMarkerD = vidMarkerQ;
    vidDigitD  = vidDigitQ;
    abortEn    = 1'b0;
    abortCode  = 3'd0;

    if (iPixelEn) begin
      bPrevD     = bar;
      vidModuleD = bar;
      vidMarkerD = (stateQ == StStart) || (stateQ == StMid) || (stateQ == StEnd);
      vidDigitD  = ((stateQ == StLeft) || (stateQ == StRight)) && digitQ[0];
      if (iLineStart) begin
        modeD = iMode;
      end

      case (stateQ)
        StIdle: begin
          if (rise && !lineBreak) begin
            stateD = StStart;
            phaseD = 2'd0;
            cntD   = CntW'(1);
            codeD  = '0;
          end
        end

        StStart: begin
          if (lineBreak) begin
            stateD = StIdle;
          end else if (phaseQ == 2'd1) begin
            if (!bar) begin
              if (cntQ >= CntMax) stateD = StIdle;
              else                cntD   = cntQ + CntW'(1);
            end else if (cntQ < CntMin) begin
              stateD = StIdle;
            end else begin
              widthD = widthFromStart;
              cntD   = CntW'(1);
              phaseD = 2'd2;
            end
          end else if (phaseQ == 2'd2) begin
            if (bar) begin
              if (cntQ >= CntMax2) stateD = StIdle;
              else                 cntD   = cntQ + CntW'(1);
            end else if (!bar2Ok) begin
              stateD = StIdle;
            end else begin
              // This pixel is the first of the first data module.
              stateD = StLeft;
              posD   = '0;
              spD    = widthQ >> 1;
              bitD   = 3'd0;
              digitD = 3'd0;
            end
          end else begin
            if (bar) begin
              if (cntQ >= CntMax) stateD = StIdle;
              else                cntD   = cntQ + CntW'(1);
            end else if (cntQ < CntMin) begin
              stateD = StIdle;
            end else begin
              w0D    = cntQ;
              cntD   = CntW'(1);
              phaseD = 2'd1;
            end
          end
        end

        default: begin
          if (lineBreak) begin
            abortEn   = 1'b1;
            abortCode = 3'd4;
          end else begin
            posD = posNext;
            if (takeSample) begin
              spD = spQ + widthQ;
              case (stateQ)
                StLeft, StRight: begin
                  if (((bitQ == 3'd0) && (bar != halfFirst)) ||
                      ((bitQ == 3'd6) && (bar == halfFirst))) begin
                    abortEn   = 1'b1;
                    abortCode = 3'd1;
                  end else begin
                    codeD = {codeQ[82:0], bar};
                    if (bitQ == 3'd6) begin
                      bitD = 3'd0;
                      if (digitQ == lastDigit) begin
                        digitD = 3'd0;
                        stateD = (stateQ == StLeft) ? StMid : StEnd;
                      end else begin
                        digitD = digitQ + 3'd1;
                      end
                    end else begin
                      bitD = bitQ + 3'd1;
                    end
                  end
                end
                StMid: begin
                  if (bar != bitQ[0]) begin
                    abortEn   = 1'b1;
                    abortCode = 3'd2;
                  end else if (bitQ == 3'd4) begin
                    bitD   = 3'd0;
                    stateD = StRight;
                  end else begin
                    bitD = bitQ + 3'd1;
                  end
                end
                default: begin
                  if (bar == bitQ[0]) begin
                    abortEn   = 1'b1;
                    abortCode = 3'd3;
                  end else if (bitQ == 3'd2) begin
                    dataCodeD = modeQ ? (codeQ & Ean8Mask) : codeQ;
                    newDataD  = 1'b1;
                    stateD    = StIdle;
                  end else begin
                    bitD = bitQ + 3'd1;
                  end
                end
              endcase
            end
          end
        end
      endcase
    end

    if (abortEn) begin
      stateD    = StIdle;
      errD      = 1'b1;
      errCodeD  = abortCode;
      newDataD  = 1'b0;
      dataCodeD = dataCodeQ;
    end
  end

  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      stateQ     <= StIdle;
      phaseQ     <= 2'd0;
      cntQ       <= '0;
      w0Q        <= '0;
      widthQ     <= '0;
      posQ       <= '0;
      spQ        <= '0;
      bitQ       <= 3'd0;
      digitQ     <= 3'd0;
      codeQ      <= '0;
      dataCodeQ  <= '0;
      newDataQ   <= 1'b0;
      errQ       <= 1'b0;
      errCodeQ   <= 3'd0;
      bPrevQ     <= 1'b0;
      modeQ      <= 1'b0;
      vidModuleQ <= 1'b0;
      vidMarkerQ <= 1'b0;
      vidDigitQ  <= 1'b0;
    end else begin
      stateQ     <= stateD;
      phaseQ     <= phaseD;
      cntQ       <= cntD;
      w0Q        <= w0D;
      widthQ     <= widthD;
      posQ       <= posD;
      spQ        <= spD;
      bitQ       <= bitD;
      digitQ     <= digitD;
      codeQ      <= codeD;
      dataCodeQ  <= dataCodeD;
      newDataQ   <= newDataD;
      errQ       <= errD;
      errCodeQ   <= errCodeD;
      bPrevQ     <= bPrevD;
      modeQ      <= modeD;
      vidModuleQ <= vidModuleD;
      vidMarkerQ <= vidMarkerD;
      vidDigitQ  <= vidDigitD;
    end
  end

  assign oVideoModule = vidModuleQ;
  assign oVideoMarker = vidMarkerQ;
  assign oVideoDigit  = vidDigitQ;
  assign oDataCode    = dataCodeQ;
  assign oNewData     = newDataQ;
  assign oErr         = errQ;
  assign oErrCode     = errCodeQ;

endmodule
